// File: rtl/usb_cdc_pkg.sv
// usb_cdc_pkg: shared arbiter state encoding and default sizing for the CDC IN path
package usb_cdc_pkg;
    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_BURST = 1'b1
    } arb_state_e;
    localparam int CDC_NUM_REQ   = 4;
    localparam int CDC_BURST_MAX = 8;
    localparam int CDC_DATA_W    = 8;
endpackage

// File: rtl/usb_cdc_in_arbiter_rr_pick.sv
// rr_pick: combinational round-robin select, first set bit of valid_i at or above ptr_i with wrap
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  valid_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  onehot_o,
    output logic [IW-1:0] idx_o,
    output logic          any_o
);
    localparam int SW = IW + 1;
    logic [N-1:0]  rot;
    logic [SW-1:0] sum;
    always_comb begin
        rot   = N'({valid_i, valid_i} >> ptr_i);
        any_o = |valid_i;
        sum   = '0;
        // scan downward so the lowest rotated offset (closest to the pointer) wins
        for (int k = N - 1; k >= 0; k--)
            if (rot[k]) sum = {1'b0, ptr_i} + SW'(k);
        idx_o    = IW'((sum >= SW'(N)) ? sum - SW'(N) : sum);
        onehot_o = any_o ? (N'(1) << idx_o) : '0;
    end
endmodule

// File: rtl/usb_cdc_in_arbiter.sv
// usb_cdc_in_arbiter: round-robin burst scheduler sharing the usb_cdc IN byte stream
// among NUM_REQ sources, gated by the core's configured status.
module usb_cdc_in_arbiter
    import usb_cdc_pkg::*;
#(
    parameter int NUM_REQ   = CDC_NUM_REQ,
    parameter int BURST_MAX = CDC_BURST_MAX,
    parameter int DATA_W    = CDC_DATA_W
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      configured_i,
    input  logic [NUM_REQ*DATA_W-1:0] req_data_i,
    input  logic [NUM_REQ-1:0]        req_valid_i,
    input  logic [NUM_REQ-1:0]        req_last_i,
    output logic [NUM_REQ-1:0]        req_ready_o,
    output logic [DATA_W-1:0]         in_data_o,
    output logic                      in_valid_o,
    input  logic                      in_ready_i,
    output logic [NUM_REQ-1:0]        grant_o,
    output logic                      abort_o
);
    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = $clog2(BURST_MAX + 1);

    arb_state_e          state_q;
    logic [IW-1:0]       rr_ptr_q, gidx_q, rr_ptr_d, pick_idx;
    logic [NUM_REQ-1:0]  grant_q, pick_onehot;
    logic [CW-1:0]       beat_cnt_q, beat_cnt_d;
    logic [DATA_W-1:0]   data_q, g_data;
    logic                valid_q, abort_q, pick_any;
    logic                in_burst, slot_free, g_valid, g_last, xfer, burst_end;

    rr_pick #(.N(NUM_REQ), .IW(IW)) u_pick (
        .valid_i  (req_valid_i),
        .ptr_i    (rr_ptr_q),
        .onehot_o (pick_onehot),
        .idx_o    (pick_idx),
        .any_o    (pick_any)
    );

    assign in_burst    = state_q == ARB_BURST;
    assign slot_free   = !valid_q || in_ready_i;
    assign g_valid     = req_valid_i[gidx_q];
    assign g_last      = req_last_i[gidx_q];
    assign g_data      = req_data_i[DATA_W*int'(gidx_q) +: DATA_W];
    assign req_ready_o = (in_burst && slot_free && configured_i) ? grant_q : '0;
    assign xfer        = in_burst && configured_i && slot_free && g_valid;
    assign beat_cnt_d  = beat_cnt_q + CW'(1);
    // an idle requester only ends the burst once the output slot could have taken its byte
    assign burst_end   = (xfer && (g_last || beat_cnt_d == CW'(BURST_MAX)))
                       || (in_burst && !g_valid && slot_free);
    assign rr_ptr_d    = (gidx_q == IW'(NUM_REQ - 1)) ? '0 : gidx_q + IW'(1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ARB_IDLE;
            rr_ptr_q   <= '0;
            gidx_q     <= '0;
            grant_q    <= '0;
            beat_cnt_q <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            abort_q    <= 1'b0;
        end else if (!configured_i) begin
            state_q <= ARB_IDLE;
            grant_q <= '0;
            valid_q <= 1'b0;
            abort_q <= in_burst || valid_q;
        end else begin
            abort_q <= 1'b0;
            if (xfer) begin
                data_q     <= g_data;
                valid_q    <= 1'b1;
                beat_cnt_q <= beat_cnt_d;
            end else if (in_ready_i) begin
                valid_q <= 1'b0;
            end
            if (!in_burst) begin
                if (pick_any) begin
                    grant_q    <= pick_onehot;
                    gidx_q     <= pick_idx;
                    beat_cnt_q <= '0;
                    state_q    <= ARB_BURST;
                end
            end else if (burst_end) begin
                state_q  <= ARB_IDLE;
                grant_q  <= '0;
                rr_ptr_q <= rr_ptr_d;
            end
        end
    end

    assign in_data_o  = data_q;
    assign in_valid_o = valid_q;
    assign grant_o    = grant_q;
    assign abort_o    = abort_q;
endmodule

// File: tb/tb_usb_cdc_in_arbiter.sv
// tb_usb_cdc_in_arbiter: directed vector table plus hand sequences for the IN arbiter
module tb_usb_cdc_in_arbiter;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        configured_i = 1'b0;
    logic [31:0] req_data_i = '0;
    logic [3:0]  req_valid_i = '0;
    logic [3:0]  req_last_i = '0;
    logic [3:0]  req_ready_o;
    logic [7:0]  in_data_o;
    logic        in_valid_o;
    logic        in_ready_i = 1'b0;
    logic [3:0]  grant_o;
    logic        abort_o;

    usb_cdc_in_arbiter #(.NUM_REQ(4), .BURST_MAX(8), .DATA_W(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .configured_i (configured_i),
        .req_data_i   (req_data_i),
        .req_valid_i  (req_valid_i),
        .req_last_i   (req_last_i),
        .req_ready_o  (req_ready_o),
        .in_data_o    (in_data_o),
        .in_valid_o   (in_valid_o),
        .in_ready_i   (in_ready_i),
        .grant_o      (grant_o),
        .abort_o      (abort_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        cfg;
        logic        rdy;
        logic [3:0]  v;
        logic [3:0]  l;
        logic [31:0] d;
        logic [3:0]  e_rdy;
        logic [3:0]  e_gnt;
        logic        e_vld;
        logic [7:0]  e_dat;
        logic        e_abt;
    } vec_t;

    vec_t       tbl[10];
    int         total = 0;
    int         bad = 0;
    int         sent[4];
    logic [7:0] outq[$];
    logic [3:0] gq[$];
    logic [3:0] vmask, lmask, prev;
    logic       cfg, rdy;
    logic [7:0] e;
    logic [3:0] exp5[5];
    int         n;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        logic [3:0] acc;
        logic       drn;
        logic [7:0] d;
        req_valid_i  = vmask;
        req_last_i   = lmask;
        configured_i = cfg;
        in_ready_i   = rdy;
        for (int i = 0; i < 4; i++) req_data_i[8*i +: 8] = {i[3:0], sent[i][3:0]};
        #1;
        if (in_valid_o && !in_ready_i) chk("ready_when_full", req_ready_o, 0);
        acc = req_valid_i & req_ready_o;
        drn = in_valid_o && in_ready_i;
        d   = in_data_o;
        @(posedge clk);
        #1;
        if (drn) outq.push_back(d);
        for (int i = 0; i < 4; i++) if (acc[i]) sent[i]++;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        vmask = '0;
        lmask = '0;
        cfg   = 1'b1;
        rdy   = 1'b1;
        req_valid_i = '0;
        req_last_i  = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) sent[i] = 0;
        outq.delete();
    endtask

    initial begin
        tbl[0] = '{1'b1, 1'b1, 4'b0001, 4'b0000, 32'h0000_00A1, 4'b0000, 4'b0001, 1'b0, 8'h00, 1'b0};
        tbl[1] = '{1'b1, 1'b1, 4'b0001, 4'b0000, 32'h0000_00A1, 4'b0001, 4'b0001, 1'b1, 8'hA1, 1'b0};
        tbl[2] = '{1'b1, 1'b1, 4'b0001, 4'b0000, 32'h0000_00A2, 4'b0001, 4'b0001, 1'b1, 8'hA2, 1'b0};
        tbl[3] = '{1'b1, 1'b1, 4'b0001, 4'b0001, 32'h0000_00A3, 4'b0001, 4'b0000, 1'b1, 8'hA3, 1'b0};
        tbl[4] = '{1'b1, 1'b1, 4'b0000, 4'b0000, 32'h0000_0000, 4'b0000, 4'b0000, 1'b0, 8'h00, 1'b0};
        tbl[5] = '{1'b1, 1'b1, 4'b0011, 4'b0010, 32'h0000_C0B0, 4'b0000, 4'b0010, 1'b0, 8'h00, 1'b0};
        tbl[6] = '{1'b1, 1'b1, 4'b0011, 4'b0010, 32'h0000_C0B0, 4'b0010, 4'b0000, 1'b1, 8'hC0, 1'b0};
        tbl[7] = '{1'b1, 1'b1, 4'b0011, 4'b0011, 32'h0000_C0B0, 4'b0000, 4'b0001, 1'b0, 8'h00, 1'b0};
        tbl[8] = '{1'b1, 1'b1, 4'b0011, 4'b0011, 32'h0000_C0B0, 4'b0001, 4'b0000, 1'b1, 8'hB0, 1'b0};
        tbl[9] = '{1'b1, 1'b1, 4'b0000, 4'b0000, 32'h0000_0000, 4'b0000, 4'b0000, 1'b0, 8'h00, 1'b0};
        exp5 = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

        // reset holds everything quiet even with requests and configuration present
        req_valid_i  = 4'hF;
        configured_i = 1'b1;
        in_ready_i   = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_grant", grant_o, 0);
        chk("rst_valid", in_valid_o, 0);
        chk("rst_data", in_data_o, 0);
        chk("rst_abort", abort_o, 0);
        chk("rst_ready", req_ready_o, 0);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            configured_i = tbl[i].cfg;
            in_ready_i   = tbl[i].rdy;
            req_valid_i  = tbl[i].v;
            req_last_i   = tbl[i].l;
            req_data_i   = tbl[i].d;
            #1;
            chk($sformatf("t1_ready_%0d", i), req_ready_o, tbl[i].e_rdy);
            @(posedge clk);
            #1;
            chk($sformatf("t1_grant_%0d", i), grant_o, tbl[i].e_gnt);
            chk($sformatf("t1_valid_%0d", i), in_valid_o, tbl[i].e_vld);
            chk($sformatf("t1_abort_%0d", i), abort_o, tbl[i].e_abt);
            if (tbl[i].e_vld) chk($sformatf("t1_data_%0d", i), in_data_o, tbl[i].e_dat);
        end

        // two continuous sources alternate in 8-beat bursts
        do_reset();
        vmask = 4'b0101;
        for (int c = 0; c < 40; c++) step();
        chk("t2_count", outq.size() >= 32, 1);
        for (int i = 0; i < 32 && i < outq.size(); i++) begin
            e = {((i / 8) % 2 != 0) ? 4'h2 : 4'h0, 4'((i / 16) * 8 + i % 8)};
            chk($sformatf("t2_byte_%0d", i), outq[i], e);
        end

        // backpressure toggling must neither drop nor repeat bytes
        do_reset();
        vmask = 4'b0010;
        for (int c = 0; c < 60; c++) begin
            rdy = (c % 2 == 0);
            step();
        end
        chk("t3_count", outq.size() >= 12, 1);
        for (int i = 0; i < 12 && i < outq.size(); i++)
            chk($sformatf("t3_byte_%0d", i), outq[i], {4'h1, i[3:0]});
        rdy = 1'b1;
        vmask = '0;
        step();

        // deconfiguration mid-burst
        do_reset();
        vmask = 4'b0001;
        n = 0;
        while (sent[0] < 4 && n < 20) begin
            step();
            n++;
        end
        chk("t4_beats", sent[0], 4);
        chk("t4_pre_abort", abort_o, 0);
        cfg = 1'b0;
        step();
        chk("t4_valid", in_valid_o, 0);
        chk("t4_grant", grant_o, 0);
        chk("t4_abort", abort_o, 1);
        for (int c = 0; c < 3; c++) begin
            step();
            chk($sformatf("t4_abort_after_%0d", c), abort_o, 0);
            chk($sformatf("t4_grant_off_%0d", c), grant_o, 0);
            chk($sformatf("t4_valid_off_%0d", c), in_valid_o, 0);
        end
        cfg = 1'b1;
        vmask = 4'b0011;
        step();
        chk("t4_ptr_kept", grant_o, 4'b0001);

        // all four request together: single-byte bursts rotate 0,1,2,3,0
        do_reset();
        vmask = 4'hF;
        lmask = 4'hF;
        prev = '0;
        gq.delete();
        for (int c = 0; c < 12; c++) begin
            step();
            if (grant_o != 0 && prev == 0) gq.push_back(grant_o);
            prev = grant_o;
        end
        chk("t5_count", gq.size() >= 5, 1);
        for (int i = 0; i < 5 && i < gq.size(); i++)
            chk($sformatf("t5_grant_%0d", i), gq[i], exp5[i]);

        // granted source goes idle after two beats while another waits
        do_reset();
        vmask = 4'b1001;
        n = 0;
        while (sent[0] < 2 && n < 20) begin
            step();
            n++;
        end
        chk("t6_beats", sent[0], 2);
        chk("t6_grant0", grant_o, 4'b0001);
        vmask = 4'b1000;
        step();
        chk("t6_idle", grant_o, 4'b0000);
        step();
        chk("t6_grant3", grant_o, 4'b1000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
